// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: constants and types shared by the writeback arbiter,
// its interface and its load-result FIFO.
//   XLEN / RA_W : data and register-address widths
//   wb_req_t    : one pending register write {rd, data}
//   wb_src_e    : which source owns the write port this cycle
package writeback_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int RA_W     = 5;
  localparam int NUM_REGS = 1 << RA_W;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU
  } wb_src_e;

endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: bundles the ALU / LSU result handshakes, the decode
// issue and scoreboard query signals, and the register-file write port.
//   master : the surrounding pipeline (drives results, issues, queries)
//   slave  : the arbiter itself
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  logic [RA_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [RA_W-1:0] lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            issue_valid;
  logic [RA_W-1:0] issue_rd;
  logic [RA_W-1:0] pend_addr1;
  logic [RA_W-1:0] pend_addr2;
  logic            pend1;
  logic            pend2;

  logic            reg_we;
  logic [RA_W-1:0] writeaddr;
  logic [XLEN-1:0] writedata;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd, pend_addr1, pend_addr2,
    input  alu_ready, lsu_ready, pend1, pend2,
    input  reg_we, writeaddr, writedata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd, pend_addr1, pend_addr2,
    output alu_ready, lsu_ready, pend1, pend2,
    output reg_we, writeaddr, writedata
  );

endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO, async active-high reset.
//   push/push_data : write side; a push while full is taken only if a pop
//                    happens in the same cycle
//   pop/pop_data   : read side; pop_data is the current head (show-ahead)
//   full/empty/count : occupancy status
// DEPTH must be a power of two so the pointers wrap for free.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr];

  // storage carries no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and load results onto the single register
// file write port and tracks outstanding destinations for decode.
//   clk, reset : clock, async active-high reset
//   bus        : writeback_arbiter_if.slave
//     alu_*    : ALU result handshake (alu_ready is the combinational grant)
//     lsu_*    : load result handshake into the load FIFO (lsu_ready = !full)
//     issue_*  : decode marks a destination pending
//     pend_*   : decode RAW queries
//     reg_we/writeaddr/writedata : registered write port
// The load FIFO is preferred; after STARVE_MAX consecutive FIFO wins while
// the ALU waits, the ALU is forced through.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 reset,
  writeback_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  wb_src_e          grant;
  wb_req_t          lq_head, lq_in, sel;
  logic             lq_full, lq_empty;
  logic [CW-1:0]    lq_count;
  logic             unused_count;
  logic [SW-1:0]    starve_cnt;
  logic             starve_hit;
  logic [NUM_REGS-1:0] pending, pending_nxt;

  assign lq_in = '{rd: bus.lsu_rd, data: bus.lsu_data};

  wb_fifo #(
    .WIDTH ($bits(wb_req_t)),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.lsu_valid && bus.lsu_ready),
    .push_data (lq_in),
    .pop       (grant == SRC_LSU),
    .pop_data  (lq_head),
    .full      (lq_full),
    .empty     (lq_empty),
    .count     (lq_count)
  );

  // occupancy comes straight from full/empty here
  assign unused_count = ^lq_count;

  assign bus.lsu_ready = !lq_full;
  assign starve_hit    = (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    grant = SRC_NONE;
    if (bus.alu_valid && (lq_empty || starve_hit)) grant = SRC_ALU;
    else if (!lq_empty)                            grant = SRC_LSU;
  end

  assign bus.alu_ready = (grant == SRC_ALU);
  assign sel = (grant == SRC_ALU) ? wb_req_t'{rd: bus.alu_rd, data: bus.alu_data}
                                  : lq_head;

  // counts FIFO wins only while the ALU is actually waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     starve_cnt <= '0;
    else if (!bus.alu_valid || grant == SRC_ALU)   starve_cnt <= '0;
    else if (grant == SRC_LSU && !starve_hit)      starve_cnt <= starve_cnt + 1'b1;
  end

  // x0 writes still consume the grant but never assert the write enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.reg_we    <= 1'b0;
      bus.writeaddr <= '0;
      bus.writedata <= '0;
    end else if (grant != SRC_NONE) begin
      bus.reg_we    <= (sel.rd != '0);
      bus.writeaddr <= sel.rd;
      bus.writedata <= sel.data;
    end else begin
      bus.reg_we    <= 1'b0;
    end
  end

  // clear first so a same-index reissue in the commit cycle keeps the bit
  always_comb begin
    pending_nxt = pending;
    if (bus.reg_we) pending_nxt[bus.writeaddr] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != '0) pending_nxt[bus.issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign bus.pend1 = pending[bus.pend_addr1];
  assign bus.pend2 = pending[bus.pend_addr2];

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed scenarios plus randomized traffic, all
// compared against a queue-based reference model of the arbiter.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int LQ_DEPTH   = 4;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  writeback_arbiter_if bus();

  writeback_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  wb_req_t         mq[$];
  int              m_starve;
  bit [NUM_REGS-1:0] m_pend;
  bit              m_we;
  logic [RA_W-1:0] m_addr;
  logic [XLEN-1:0] m_data;

  // writes observed on the DUT port, {addr, data}
  logic [RA_W+XLEN-1:0] dlog[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.issue_valid = 0; bus.issue_rd = '0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_starve = 0;
    m_pend = '0;
    m_we = 0; m_addr = '0; m_data = '0;
  endtask

  // called at a negedge with inputs already driven; returns at the next negedge
  task automatic step();
    bit      empty_m, alu_g, lsu_g, lr;
    wb_req_t head;
    #1;
    empty_m = (mq.size() == 0);
    lr      = (mq.size() < LQ_DEPTH);
    alu_g   = bus.alu_valid && (empty_m || m_starve == STARVE_MAX);
    lsu_g   = !alu_g && !empty_m;
    chk("alu_ready", bus.alu_ready, alu_g);
    chk("lsu_ready", bus.lsu_ready, lr);
    chk("pend1", bus.pend1, m_pend[bus.pend_addr1]);
    chk("pend2", bus.pend2, m_pend[bus.pend_addr2]);

    if (m_we) m_pend[m_addr] = 0;
    if (bus.issue_valid && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1;
    head = '0;
    if (lsu_g) head = mq.pop_front();
    if (bus.lsu_valid && lr) mq.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
    if (bus.alu_valid && lsu_g) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
    else                        m_starve = 0;
    if (alu_g) begin
      m_we = (bus.alu_rd != 0); m_addr = bus.alu_rd; m_data = bus.alu_data;
    end else if (lsu_g) begin
      m_we = (head.rd != 0); m_addr = head.rd; m_data = head.data;
    end else begin
      m_we = 0;
    end

    @(posedge clk);
    @(negedge clk);
    chk("reg_we", bus.reg_we, m_we);
    if (m_we) begin
      chk("writeaddr", bus.writeaddr, m_addr);
      chk("writedata", bus.writedata, m_data);
    end
    if (bus.reg_we) dlog.push_back({bus.writeaddr, bus.writedata});
  endtask

  // reset for one cycle with whatever inputs are currently offered
  task automatic do_reset();
    reset = 1;
    bus.pend_addr1 = 5;
    #1;
    chk("rst_reg_we", bus.reg_we, 0);
    chk("rst_lsu_ready", bus.lsu_ready, 1);
    chk("rst_writeaddr", bus.writeaddr, 0);
    chk("rst_writedata", bus.writedata, 0);
    chk("rst_pend_x5", bus.pend1, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin : main
    int k, acc;
    bit saw_full;
    logic [RA_W-1:0] exp_seq[6];
    logic [RA_W-1:0] r;

    idle_inputs();
    bus.pend_addr1 = '0; bus.pend_addr2 = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // ALU only
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'h1234;
    step();
    chk("alu_only_we", bus.reg_we, 1);
    chk("alu_only_addr", bus.writeaddr, 3);
    chk("alu_only_data", bus.writedata, 32'h1234);
    idle_inputs();
    step();

    // starvation: FIFO kept busy, ALU waits with rd 7
    dlog.delete();
    bus.lsu_valid = 1; bus.lsu_rd = 10; bus.lsu_data = 32'hC000 + 10;
    step();
    for (k = 1; k <= 6; k++) begin
      bus.alu_valid = (k <= 5); bus.alu_rd = 7; bus.alu_data = 32'h7777;
      bus.lsu_rd = RA_W'(10 + k); bus.lsu_data = 32'hC000 + k + 10;
      step();
    end
    idle_inputs();
    exp_seq = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd7, 5'd14};
    chk("starve_nwrites", dlog.size() >= 6, 1);
    for (k = 0; k < 6 && k < dlog.size(); k++)
      chk($sformatf("starve_order%0d", k), dlog[k][RA_W+XLEN-1:XLEN], exp_seq[k]);
    for (k = 0; k < 12; k++) step();

    // backpressure: ALU keeps stealing slots so the FIFO fills
    dlog.delete();
    saw_full = 0; acc = 0; k = 0;
    while (acc < 20 && k < 200) begin
      bus.alu_valid = 1; bus.alu_rd = 20; bus.alu_data = 32'hA000 + k;
      bus.lsu_valid = 1; bus.lsu_rd = RA_W'((acc % 5) + 1); bus.lsu_data = 32'hB000 + acc;
      #1;
      if (!bus.lsu_ready) saw_full = 1;
      else acc++;
      #(-1 + 1);
      step();
      k++;
    end
    idle_inputs();
    for (k = 0; k < 10; k++) step();
    chk("bp_saw_full", saw_full, 1);
    acc = 0;
    foreach (dlog[i]) begin
      if (dlog[i][XLEN-1:12] == 20'hB) begin
        chk("bp_seq_data", dlog[i][XLEN-1:0], 32'hB000 + acc);
        chk("bp_seq_rd", dlog[i][RA_W+XLEN-1:XLEN], (acc % 5) + 1);
        acc++;
      end
    end
    chk("bp_count", acc, 20);

    // x0 suppression
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hFFFF;
    bus.issue_valid = 1; bus.issue_rd = 0; bus.pend_addr1 = 0;
    #1;
    chk("x0_alu_ready", bus.alu_ready, 1);
    step();
    idle_inputs();
    chk("x0_we", bus.reg_we, 0);
    chk("x0_pend", bus.pend1, 0);
    step();

    // scoreboard race on x9
    bus.pend_addr1 = 9;
    bus.issue_valid = 1; bus.issue_rd = 9;
    step();
    idle_inputs();
    chk("race_pend_set", bus.pend1, 1);
    bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_data = 32'h99;
    step();
    idle_inputs();
    chk("race_commit_we", bus.reg_we, 1);
    bus.issue_valid = 1; bus.issue_rd = 9;
    step();
    idle_inputs();
    chk("race_pend_kept", bus.pend1, 1);
    bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_data = 32'h9A;
    step();
    idle_inputs();
    chk("race_pend_before_clear", bus.pend1, 1);
    step();
    chk("race_pend_cleared", bus.pend1, 0);

    // reset mid-stream: pending x5, FIFO holding 3 entries
    bus.issue_valid = 1; bus.issue_rd = 5;
    step();
    for (k = 0; k < 11; k++) begin
      bus.issue_valid = 0;
      bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 32'hD000 + k;
      bus.lsu_valid = 1; bus.lsu_rd = 6; bus.lsu_data = 32'hE000 + k;
      step();
    end
    chk("mid_fifo_fill", mq.size(), 3);
    do_reset();
    idle_inputs();
    step();
    chk("post_rst_we", bus.reg_we, 0);
    step();
    chk("post_rst_we2", bus.reg_we, 0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      bus.alu_valid = ($urandom_range(99) < 50);
      bus.alu_rd    = RA_W'($urandom);
      bus.alu_data  = $urandom;
      bus.lsu_valid = ($urandom_range(99) < 60);
      bus.lsu_rd    = RA_W'($urandom);
      bus.lsu_data  = $urandom;
      r = RA_W'($urandom);
      bus.issue_valid = ($urandom_range(99) < 30) && !m_pend[r];
      bus.issue_rd    = r;
      bus.pend_addr1  = RA_W'($urandom);
      bus.pend_addr2  = RA_W'($urandom);
      if ($urandom_range(199) == 0) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
